// File: rtl/i_buffer_if.sv
// Decode-to-issue handshake bundle for i_buffer: producer push side, consumer show-ahead side, flush and occupancy.
interface i_buffer_if #(
  parameter int PTR_W = 3
);
  logic             flush;
  logic             id_valid;
  logic             id_vacant;
  logic [6:0]       id_opt;
  logic [2:0]       id_funct;
  logic [5:0]       id_rs1;
  logic [5:0]       id_rs2;
  logic [5:0]       id_rd;
  logic [31:0]      id_imm;
  logic             is_ready;
  logic             is_valid;
  logic [6:0]       is_opt;
  logic [2:0]       is_funct;
  logic [5:0]       is_rs1;
  logic [5:0]       is_rs2;
  logic [5:0]       is_rd;
  logic [31:0]      is_imm;
  logic [PTR_W:0]   count;

  modport master (
    output flush, id_valid, id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm, is_ready,
    input  id_vacant, is_valid, is_opt, is_funct, is_rs1, is_rs2, is_rd, is_imm, count
  );

  modport slave (
    input  flush, id_valid, id_opt, id_funct, id_rs1, id_rs2, id_rd, id_imm, is_ready,
    output id_vacant, is_valid, is_opt, is_funct, is_rs1, is_rs2, is_rd, is_imm, count
  );
endinterface

// File: rtl/i_buffer.sv
// Circular FIFO of decoded instructions; 1-cycle push-to-head latency, no flow-through.
// Backpressure: id_vacant drops only when full (no full-bypass); is_ready ignored while empty; flush wins.
module i_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic      clk,
  input  logic      rst,
  i_buffer_if.slave bus
);

  typedef struct packed {
    logic [6:0]  opt;
    logic [2:0]  funct;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] imm;
  } entry_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           rd_entry;

  assign bus.id_vacant = (count != CNT_FULL);
  assign bus.is_valid  = (count != '0);
  assign bus.count     = count;

  assign push = bus.id_valid & bus.id_vacant;
  assign pop  = bus.is_valid & bus.is_ready;

  assign wr_entry = '{opt: bus.id_opt, funct: bus.id_funct, rs1: bus.id_rs1,
                      rs2: bus.id_rs2, rd: bus.id_rd, imm: bus.id_imm};

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && push) mem[tail] <= wr_entry;
  end

  assign rd_entry     = bus.is_valid ? mem[head] : '0;
  assign bus.is_opt   = rd_entry.opt;
  assign bus.is_funct = rd_entry.funct;
  assign bus.is_rs1   = rd_entry.rs1;
  assign bus.is_rs2   = rd_entry.rs2;
  assign bus.is_rd    = rd_entry.rd;
  assign bus.is_imm   = rd_entry.imm;

endmodule

// File: tb/tb_i_buffer.sv
// Directed bench for i_buffer: reset, single pass, fill/full, wrap streaming, flush, vector regs, mid-stream reset.
module tb_i_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  i_buffer_if #(.PTR_W(3)) bus ();

  i_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input logic [6:0] o, input logic [2:0] f, input logic [5:0] r1,
                           input logic [5:0] r2, input logic [5:0] d, input logic [31:0] im);
    bus.id_opt   = o;
    bus.id_funct = f;
    bus.id_rs1   = r1;
    bus.id_rs2   = r2;
    bus.id_rd    = d;
    bus.id_imm   = im;
  endtask

  function automatic logic [63:0] head_word();
    return {4'h0, bus.is_opt, bus.is_funct, bus.is_rs1, bus.is_rs2, bus.is_rd, bus.is_imm};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.id_valid = 1'b1;
    bus.is_ready = 1'b0;
    set_entry(7'h7F, 3'h7, 6'h3F, 6'h3F, 6'h3F, 32'hDEAD_BEEF);

    // 1. reset held two cycles with id_valid asserted
    tick();
    tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_is_valid", 64'(bus.is_valid), 64'd0);
    chk("rst_fields", head_word(), 64'd0);
    chk("rst_vacant", 64'(bus.id_vacant), 64'd1);
    rst = 1'b1;
    bus.id_valid = 1'b0;

    // 2. single pass
    set_entry(7'h13, 3'h0, 6'd1, 6'd0, 6'd2, 32'hFFFF_FFFC);
    bus.id_valid = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    chk("single_valid", 64'(bus.is_valid), 64'd1);
    chk("single_fields", head_word(), {4'h0, 7'h13, 3'h0, 6'd1, 6'd0, 6'd2, 32'hFFFF_FFFC});
    chk("single_count", 64'(bus.count), 64'd1);
    bus.is_ready = 1'b1;
    tick();
    bus.is_ready = 1'b0;
    chk("single_pop_valid", 64'(bus.is_valid), 64'd0);
    chk("single_pop_count", 64'(bus.count), 64'd0);

    // 3. fill to full, drop a 9th push, push ignored during a full-cycle pop, then drain
    bus.id_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_entry(7'(i), 3'(i), 6'(i), 6'(i), 6'(i), 32'(i));
      tick();
    end
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_vacant", 64'(bus.id_vacant), 64'd0);
    set_entry(7'h55, 3'h5, 6'h15, 6'h15, 6'h15, 32'd99);
    tick();
    chk("full_drop_count", 64'(bus.count), 64'd8);
    chk("full_drop_head", 64'(bus.is_imm), 64'd0);
    bus.is_ready = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    chk("full_pop_count", 64'(bus.count), 64'd7);
    chk("full_pop_vacant", 64'(bus.id_vacant), 64'd1);
    for (int i = 1; i < 8; i++) begin
      chk("drain_valid", 64'(bus.is_valid), 64'd1);
      chk("drain_imm", 64'(bus.is_imm), 64'(i));
      chk("drain_rs1", 64'(bus.is_rs1), 64'(i));
      tick();
    end
    bus.is_ready = 1'b0;
    chk("drain_empty_count", 64'(bus.count), 64'd0);
    chk("drain_empty_valid", 64'(bus.is_valid), 64'd0);

    // 4. push 6, pop 6, then stream 20 across the pointer wrap
    bus.id_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_entry(7'h33, 3'h1, 6'd3, 6'd4, 6'd5, 32'(100 + i));
      tick();
    end
    bus.id_valid = 1'b0;
    chk("p6_count", 64'(bus.count), 64'd6);
    bus.is_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("p6_imm", 64'(bus.is_imm), 64'(100 + i));
      tick();
    end
    chk("p6_empty", 64'(bus.count), 64'd0);
    bus.id_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_entry(7'h33, 3'h2, 6'd7, 6'd8, 6'd9, 32'(200 + k));
      if (k > 0) begin
        chk("stream_count", 64'(bus.count), 64'd1);
        chk("stream_imm", 64'(bus.is_imm), 64'(200 + k - 1));
      end
      tick();
    end
    bus.id_valid = 1'b0;
    chk("stream_last_imm", 64'(bus.is_imm), 64'd219);
    chk("stream_last_count", 64'(bus.count), 64'd1);
    tick();
    bus.is_ready = 1'b0;
    chk("stream_done_count", 64'(bus.count), 64'd0);

    // 5. flush with concurrent push and pop
    bus.id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_entry(7'h44, 3'h3, 6'd1, 6'd1, 6'd1, 32'(300 + i));
      tick();
    end
    chk("pre_flush_count", 64'(bus.count), 64'd5);
    set_entry(7'h44, 3'h3, 6'd1, 6'd1, 6'd1, 32'd399);
    bus.flush = 1'b1;
    bus.is_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.is_ready = 1'b0;
    bus.id_valid = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.is_valid), 64'd0);
    chk("flush_fields", head_word(), 64'd0);
    set_entry(7'h44, 3'h3, 6'd1, 6'd1, 6'd1, 32'd400);
    bus.id_valid = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    chk("post_flush_count", 64'(bus.count), 64'd1);
    chk("post_flush_imm", 64'(bus.is_imm), 64'd400);
    bus.is_ready = 1'b1;
    tick();
    bus.is_ready = 1'b0;

    // 6. vector register operands keep bit5
    set_entry(7'h57, 3'h7, 6'h21, 6'h3F, 6'h20, 32'h8000_0001);
    bus.id_valid = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    chk("vec_rs1", 64'(bus.is_rs1), 64'h21);
    chk("vec_rs2", 64'(bus.is_rs2), 64'h3F);
    chk("vec_rd", 64'(bus.is_rd), 64'h20);
    chk("vec_fields", head_word(), {4'h0, 7'h57, 3'h7, 6'h21, 6'h3F, 6'h20, 32'h8000_0001});
    bus.is_ready = 1'b1;
    tick();
    bus.is_ready = 1'b0;
    chk("vec_pop_count", 64'(bus.count), 64'd0);

    // 7. reset while holding entries
    bus.id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_entry(7'h11, 3'h4, 6'd2, 6'd3, 6'd4, 32'(500 + i));
      tick();
    end
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    set_entry(7'h11, 3'h4, 6'd2, 6'd3, 6'd4, 32'd599);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.id_valid = 1'b0;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_valid", 64'(bus.is_valid), 64'd0);
    bus.id_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_entry(7'h11, 3'h4, 6'd2, 6'd3, 6'd4, 32'(600 + i));
      tick();
    end
    bus.id_valid = 1'b0;
    chk("restart_count", 64'(bus.count), 64'd2);
    chk("restart_head0", 64'(bus.is_imm), 64'd600);
    bus.is_ready = 1'b1;
    tick();
    chk("restart_head1", 64'(bus.is_imm), 64'd601);
    tick();
    bus.is_ready = 1'b0;
    chk("restart_empty", 64'(bus.count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
